// File: rtl/muldiv_ctrl_if.sv
// Request, result and HI/LO bundle between main control, the mul/div units
// and muldiv_ctrl. Optional abort input present when MULDIV_ABORT_EN is set.
interface muldiv_ctrl_if;
  logic        op_start;
  logic        op_is_div;
  logic        div_en;
  logic        mult_en;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        div_err;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic        hilo_wr;
  logic        hilo_sel;
  logic [31:0] hilo_wdata;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_zero;
`ifdef MULDIV_ABORT_EN
  logic        abort;

  modport master (
    output op_start, op_is_div,
    output div_hi, div_lo, div_err,
    output mult_hi, mult_lo,
    output hilo_wr, hilo_sel, hilo_wdata,
    output abort,
    input  div_en, mult_en,
    input  hi_out, lo_out,
    input  busy, done, div_zero
  );

  modport slave (
    input  op_start, op_is_div,
    input  div_hi, div_lo, div_err,
    input  mult_hi, mult_lo,
    input  hilo_wr, hilo_sel, hilo_wdata,
    input  abort,
    output div_en, mult_en,
    output hi_out, lo_out,
    output busy, done, div_zero
  );
`else
  modport master (
    output op_start, op_is_div,
    output div_hi, div_lo, div_err,
    output mult_hi, mult_lo,
    output hilo_wr, hilo_sel, hilo_wdata,
    input  div_en, mult_en,
    input  hi_out, lo_out,
    input  busy, done, div_zero
  );

  modport slave (
    input  op_start, op_is_div,
    input  div_hi, div_lo, div_err,
    input  mult_hi, mult_lo,
    input  hilo_wr, hilo_sel, hilo_wdata,
    output div_en, mult_en,
    output hi_out, lo_out,
    output busy, done, div_zero
  );
`endif
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/DIV sequencer owning the architectural HI/LO registers.
// Define MULDIV_ABORT_EN to add the abort input (RUN/CAPTURE -> IDLE).
module muldiv_ctrl #(
  parameter int DIV_CYCLES  = 33,
  parameter int MULT_CYCLES = 33,
  parameter int CNT_W       = 6
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] DIV_LAST =
    CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MULT_LAST =
    CNT_W'(MULT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             div_en_q, div_en_d;
  logic             mult_en_q, mult_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             abort;
  logic             last;

`ifdef MULDIV_ABORT_EN
  assign abort = bus.abort;
`else
  assign abort = 1'b0;
`endif

  // op_q selects which unit's cycle count ends RUN
  assign last = (cnt_q == (op_q ? DIV_LAST : MULT_LAST));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    div_en_d  = div_en_q;
    mult_en_d = mult_en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.hilo_wr) begin
          if (bus.hilo_sel) hi_d = bus.hilo_wdata;
          else              lo_d = bus.hilo_wdata;
        end
        if (bus.op_start) begin
          state_d   = RUN;
          op_d      = bus.op_is_div;
          cnt_d     = '0;
          dz_d      = 1'b0;
          div_en_d  = bus.op_is_div;
          mult_en_d = ~bus.op_is_div;
          busy_d    = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = IDLE;
          div_en_d  = 1'b0;
          mult_en_d = 1'b0;
          busy_d    = 1'b0;
        end else if (op_q && bus.div_err) begin
          state_d  = DONE;
          div_en_d = 1'b0;
          dz_d     = 1'b1;
          done_d   = 1'b1;
        end else if (last) begin
          state_d   = CAPTURE;
          div_en_d  = 1'b0;
          mult_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          hi_d    = op_q ? bus.div_hi : bus.mult_hi;
          lo_d    = op_q ? bus.div_lo : bus.mult_lo;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        div_en_d  = 1'b0;
        mult_en_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      div_en_q  <= 1'b0;
      mult_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      div_en_q  <= div_en_d;
      mult_en_q <= mult_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.div_en   = div_en_q;
  assign bus.mult_en  = mult_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with behavioural mul/div unit models.
// Define MULDIV_ABORT_EN to also exercise the abort path.
module tb_muldiv_ctrl;

  localparam int N = 33;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clk;
  logic reset;
  muldiv_ctrl_if bus();

  logic [31:0] op_a, op_b;
  logic [63:0] prod;

  exp_t sb[$];
  exp_t e;
  int   checks, errors;

  logic [31:0] cur_hi, cur_lo;
  int   div_cnt, mult_cnt, busy_cnt, done_cnt, done_at;
  logic ended;
  logic [31:0] obs_hi, obs_lo, hi_c1;
  logic obs_dz, dz_c1;

  muldiv_ctrl #(
    .DIV_CYCLES (N),
    .MULT_CYCLES(N),
    .CNT_W      (6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // units hold results while disabled; divide-by-zero yields garbage
  assign prod = {32'b0, op_a} * {32'b0, op_b};
  assign bus.mult_hi = prod[63:32];
  assign bus.mult_lo = prod[31:0];
  assign bus.div_hi = (op_b == 0) ? 32'hFFFF_FFFF : op_a % op_b;
  assign bus.div_lo = (op_b == 0) ? 32'hFFFF_FFFF : op_a / op_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(input logic is_div,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int err_at,
                        input int mid_at,
                        input int abort_at);
    op_a = a;
    op_b = b;
    bus.op_is_div = is_div;
    bus.op_start = 1'b1;
    @(negedge clk);
    bus.op_start = 1'b0;
    bus.hilo_wr = 1'b0;
    div_cnt = 0;
    mult_cnt = 0;
    busy_cnt = 0;
    done_cnt = 0;
    done_at = 0;
    ended = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (k == 1) begin
        hi_c1 = bus.hi_out;
        dz_c1 = bus.div_zero;
      end
      if (!bus.busy) begin
        ended = 1'b1;
        break;
      end
      busy_cnt++;
      if (bus.div_en) div_cnt++;
      if (bus.mult_en) mult_cnt++;
      if (bus.done) begin
        if (done_cnt == 0) begin
          done_at = k;
          obs_hi = bus.hi_out;
          obs_lo = bus.lo_out;
          obs_dz = bus.div_zero;
        end
        done_cnt++;
      end
      bus.div_err = (k == err_at);
      bus.op_start = (k == mid_at);
      bus.hilo_wr = (k == mid_at);
`ifdef MULDIV_ABORT_EN
      bus.abort = (k == abort_at);
`else
      if (abort_at > 0 && k == abort_at) bus.div_err = 1'b0;
`endif
      @(negedge clk);
    end
    bus.div_err = 1'b0;
    bus.op_start = 1'b0;
    bus.hilo_wr = 1'b0;
`ifdef MULDIV_ABORT_EN
    bus.abort = 1'b0;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.op_start = 1'b0;
    bus.op_is_div = 1'b0;
    bus.div_err = 1'b0;
    bus.hilo_wr = 1'b0;
    bus.hilo_sel = 1'b0;
    bus.hilo_wdata = '0;
`ifdef MULDIV_ABORT_EN
    bus.abort = 1'b0;
`endif
    op_a = 0;
    op_b = 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cur_hi = 0;
    cur_lo = 0;
    checks++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000",
               {bus.busy, bus.done, bus.div_zero});
    end
    checks++;
    if ({bus.div_en, bus.mult_en} !== 2'b00) begin
      errors++;
      $display("FAIL reset_en: got %b want 00",
               {bus.div_en, bus.mult_en});
    end
    checks++;
    if ({bus.hi_out, bus.lo_out} !== 64'h0) begin
      errors++;
      $display("FAIL reset_hilo: got %h want 0",
               {bus.hi_out, bus.lo_out});
    end
  endtask

  task automatic test_div();
    cur_hi = 100 % 7;
    cur_lo = 100 / 7;
    sb.push_back('{hi: cur_hi, lo: cur_lo, dz: 1'b0});
    run_op(1'b1, 100, 7, 0, 0, 0);
    checks++;
    if (ended !== 1'b1) begin
      errors++;
      $display("FAIL div_timeout: busy never fell");
    end
    checks++;
    if (div_cnt != N || mult_cnt != 0) begin
      errors++;
      $display("FAIL div_en_cycles: got %0d/%0d want %0d/0",
               div_cnt, mult_cnt, N);
    end
    checks++;
    if (done_at != N + 2 || done_cnt != 1) begin
      errors++;
      $display("FAIL div_done: got at %0d x%0d want at %0d x1",
               done_at, done_cnt, N + 2);
    end
    checks++;
    if (busy_cnt != N + 2) begin
      errors++;
      $display("FAIL div_busy: got %0d want %0d",
               busy_cnt, N + 2);
    end
    e = sb.pop_front();
    checks++;
    if (obs_hi !== e.hi || obs_lo !== e.lo || obs_dz !== e.dz) begin
      errors++;
      $display("FAIL div_result: got %h/%h/%b want %h/%h/%b",
               obs_hi, obs_lo, obs_dz, e.hi, e.lo, e.dz);
    end
  endtask

  task automatic test_mult();
    logic [31:0] av [2];
    logic [31:0] bv [2];
    logic [63:0] p;
    av[0] = 6;
    bv[0] = 7;
    av[1] = 32'h1234_5678;
    bv[1] = 32'h0000_0100;
    for (int i = 0; i < 2; i++) begin
      p = {32'b0, av[i]} * {32'b0, bv[i]};
      cur_hi = p[63:32];
      cur_lo = p[31:0];
      sb.push_back('{hi: cur_hi, lo: cur_lo, dz: 1'b0});
      run_op(1'b0, av[i], bv[i], 0, 0, 0);
      checks++;
      if (mult_cnt != N || div_cnt != 0) begin
        errors++;
        $display("FAIL mult_en_cycles[%0d]: got %0d/%0d want %0d/0",
                 i, mult_cnt, div_cnt, N);
      end
      checks++;
      if (done_at != N + 2 || !ended) begin
        errors++;
        $display("FAIL mult_done[%0d]: got %0d want %0d",
                 i, done_at, N + 2);
      end
      e = sb.pop_front();
      checks++;
      if (obs_hi !== e.hi || obs_lo !== e.lo) begin
        errors++;
        $display("FAIL mult_result[%0d]: got %h/%h want %h/%h",
                 i, obs_hi, obs_lo, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_div_zero();
    sb.push_back('{hi: cur_hi, lo: cur_lo, dz: 1'b1});
    run_op(1'b1, 55, 0, 1, 0, 0);
    checks++;
    if (done_at != 2 || div_cnt != 1 || busy_cnt != 2) begin
      errors++;
      $display("FAIL dz_timing: got done %0d en %0d busy %0d want 2 1 2",
               done_at, div_cnt, busy_cnt);
    end
    e = sb.pop_front();
    checks++;
    if (obs_hi !== e.hi || obs_lo !== e.lo || obs_dz !== e.dz) begin
      errors++;
      $display("FAIL dz_result: got %h/%h/%b want %h/%h/%b",
               obs_hi, obs_lo, obs_dz, e.hi, e.lo, e.dz);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.div_zero !== 1'b1 || bus.hi_out !== cur_hi) begin
      errors++;
      $display("FAIL dz_sticky: got %b/%h want 1/%h",
               bus.div_zero, bus.hi_out, cur_hi);
    end
    cur_hi = 0;
    cur_lo = 6;
    sb.push_back('{hi: cur_hi, lo: cur_lo, dz: 1'b0});
    run_op(1'b0, 2, 3, 0, 0, 0);
    checks++;
    if (dz_c1 !== 1'b0) begin
      errors++;
      $display("FAIL dz_clear: got %b want 0", dz_c1);
    end
    e = sb.pop_front();
    checks++;
    if (obs_hi !== e.hi || obs_lo !== e.lo || obs_dz !== e.dz) begin
      errors++;
      $display("FAIL dz_next: got %h/%h/%b want %h/%h/%b",
               obs_hi, obs_lo, obs_dz, e.hi, e.lo, e.dz);
    end
  endtask

  task automatic test_busy_ignore();
    bus.hilo_sel = 1'b1;
    bus.hilo_wdata = 32'hDEAD_BEEF;
    cur_hi = 0;
    cur_lo = 15;
    sb.push_back('{hi: cur_hi, lo: cur_lo, dz: 1'b0});
    run_op(1'b0, 3, 5, 0, 10, 0);
    checks++;
    if (done_cnt != 1 || busy_cnt != N + 2) begin
      errors++;
      $display("FAIL busy_mid: got done x%0d busy %0d want x1 %0d",
               done_cnt, busy_cnt, N + 2);
    end
    e = sb.pop_front();
    checks++;
    if (obs_hi !== e.hi || obs_lo !== e.lo) begin
      errors++;
      $display("FAIL busy_result: got %h/%h want %h/%h",
               obs_hi, obs_lo, e.hi, e.lo);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.hi_out !== cur_hi) begin
      errors++;
      $display("FAIL busy_noqueue: got %b/%h want 0/%h",
               bus.busy, bus.hi_out, cur_hi);
    end
  endtask

  task automatic test_hilo_idle();
    bus.hilo_sel = 1'b1;
    bus.hilo_wdata = 32'hDEAD_BEEF;
    bus.hilo_wr = 1'b1;
    @(negedge clk);
    bus.hilo_wr = 1'b0;
    cur_hi = 32'hDEAD_BEEF;
    checks++;
    if (bus.hi_out !== cur_hi || bus.lo_out !== cur_lo) begin
      errors++;
      $display("FAIL hilo_hi: got %h/%h want %h/%h",
               bus.hi_out, bus.lo_out, cur_hi, cur_lo);
    end
    bus.hilo_sel = 1'b0;
    bus.hilo_wdata = 32'hCAFE_F00D;
    bus.hilo_wr = 1'b1;
    @(negedge clk);
    bus.hilo_wr = 1'b0;
    cur_lo = 32'hCAFE_F00D;
    checks++;
    if (bus.hi_out !== cur_hi || bus.lo_out !== cur_lo) begin
      errors++;
      $display("FAIL hilo_lo: got %h/%h want %h/%h",
               bus.hi_out, bus.lo_out, cur_hi, cur_lo);
    end
    bus.hilo_sel = 1'b1;
    bus.hilo_wdata = 32'h1111_1111;
    bus.hilo_wr = 1'b1;
    cur_hi = 0;
    cur_lo = 42;
    sb.push_back('{hi: cur_hi, lo: cur_lo, dz: 1'b0});
    run_op(1'b0, 6, 7, 0, 0, 0);
    checks++;
    if (hi_c1 !== 32'h1111_1111) begin
      errors++;
      $display("FAIL hilo_with_start: got %h want 11111111", hi_c1);
    end
    e = sb.pop_front();
    checks++;
    if (obs_hi !== e.hi || obs_lo !== e.lo) begin
      errors++;
      $display("FAIL hilo_overwrite: got %h/%h want %h/%h",
               obs_hi, obs_lo, e.hi, e.lo);
    end
  endtask

  task automatic test_reset_mid();
    op_a = 100;
    op_b = 7;
    bus.op_is_div = 1'b1;
    bus.op_start = 1'b1;
    @(negedge clk);
    bus.op_start = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (bus.div_en !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got %b%b want 11",
               bus.div_en, bus.busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.div_en, bus.mult_en, bus.busy, bus.done,
         bus.div_zero} !== 5'b0 ||
        {bus.hi_out, bus.lo_out} !== 64'h0) begin
      errors++;
      $display("FAIL rst_mid_async: got %b %h want 0",
               {bus.div_en, bus.busy, bus.done},
               {bus.hi_out, bus.lo_out});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cur_hi = 100 % 7;
    cur_lo = 100 / 7;
    sb.push_back('{hi: cur_hi, lo: cur_lo, dz: 1'b0});
    run_op(1'b1, 100, 7, 0, 0, 0);
    checks++;
    if (div_cnt != N || done_at != N + 2) begin
      errors++;
      $display("FAIL rst_mid_rerun: got en %0d done %0d want %0d %0d",
               div_cnt, done_at, N, N + 2);
    end
    e = sb.pop_front();
    checks++;
    if (obs_hi !== e.hi || obs_lo !== e.lo || obs_dz !== e.dz) begin
      errors++;
      $display("FAIL rst_mid_result: got %h/%h/%b want %h/%h/%b",
               obs_hi, obs_lo, obs_dz, e.hi, e.lo, e.dz);
    end
  endtask

`ifdef MULDIV_ABORT_EN
  task automatic test_abort();
    run_op(1'b1, 999, 10, 0, 0, 5);
    checks++;
    if (busy_cnt != 5 || div_cnt != 5 || done_cnt != 0) begin
      errors++;
      $display("FAIL abort_timing: got busy %0d en %0d done %0d want 5 5 0",
               busy_cnt, div_cnt, done_cnt);
    end
    checks++;
    if (bus.hi_out !== cur_hi || bus.lo_out !== cur_lo ||
        bus.div_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_hilo: got %h/%h want %h/%h",
               bus.hi_out, bus.lo_out, cur_hi, cur_lo);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_div();
    test_mult();
    test_div_zero();
    test_busy_ignore();
    test_hilo_idle();
    test_reset_mid();
`ifdef MULDIV_ABORT_EN
    test_abort();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: got %0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
